// File: rtl/udc_pkg.sv
// Shared definitions for the up/down-counter job sequencer: FSM state
// encoding, default data width and the step-counter width helper.
package udc_pkg;

    localparam int WIDTH_DEF = 8;

    // A bounce job needs up to 2*2^WIDTH - 1 cycles; two extra bits cover it.
    function automatic int steps_w(input int w);
        return w + 2;
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/udc_sequencer_if.sv
// Job request bus into the sequencer: valid/ready handshake plus the
// job description (start value, limit, direction, bounce).
interface udc_sequencer_if
    import udc_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) ();

    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_init;
    logic [WIDTH-1:0] cmd_limit;
    logic             cmd_dir;
    logic             cmd_bounce;

    modport master (
        output cmd_valid, cmd_init, cmd_limit, cmd_dir, cmd_bounce,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_init, cmd_limit, cmd_dir, cmd_bounce,
        output cmd_ready
    );

endinterface

// File: rtl/udc_sequencer.sv
// Command-driven controller for one external 8-bit up/down counter:
// loads the start value, steers direction, detects the end and reports.
module udc_sequencer
    import udc_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SW    = steps_w(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    udc_sequencer_if.slave       cmd,
    input  logic                 abort,
    output logic                 ctr_rst,
    output logic                 ctr_mode,
    output logic [WIDTH-1:0]     ctr_init,
    input  logic [WIDTH-1:0]     ctr_count,
    output logic                 busy,
    output logic                 done,
    output logic [SW-1:0]        res_steps,
    output logic                 res_aborted
);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_LOAD = LOAD;
    localparam logic [1:0] ST_RUN  = RUN;
    localparam logic [1:0] ST_DONE = DONE;

    logic [1:0]       state;
    logic [WIDTH-1:0] limit_q;
    logic             dir_q;
    logic             bounce_q;
    logic             leg;
    logic [SW-1:0]    steps;

    logic [WIDTH-1:0] target;
    logic             hit;
    logic             same;
    logic             final_hit;
    logic             turn;

    always_comb begin
        target    = leg ? ctr_init : limit_q;
        hit       = (state == ST_RUN) && (ctr_count == target);
        same      = (ctr_init == limit_q);
        final_hit = hit && (leg || !bounce_q || same);
        turn      = hit && !leg && bounce_q && !same;
    end

    assign cmd.cmd_ready = (state == ST_IDLE);
    assign busy          = (state != ST_IDLE);
    assign done          = (state == ST_DONE);

    // The counter only free-runs in RUN; on the final hit or an abort it is
    // reloaded in the same edge so it never steps past the target.
    assign ctr_rst = (state == ST_RUN) && !final_hit && !abort;

    always_comb begin
        ctr_mode = 1'b1;
        if (state == ST_LOAD) begin
            ctr_mode = dir_q;
        end else if (state == ST_RUN) begin
            ctr_mode = (leg || (hit && bounce_q)) ? ~dir_q : dir_q;
        end
    end

    always_ff @(posedge clk) begin
        if (state == ST_IDLE && cmd.cmd_valid) begin
            limit_q  <= cmd.cmd_limit;
            dir_q    <= cmd.cmd_dir;
            bounce_q <= cmd.cmd_bounce;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_IDLE;
            ctr_init    <= '0;
            res_steps   <= '0;
            res_aborted <= 1'b0;
            leg         <= 1'b0;
            steps       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd.cmd_valid) begin
                        ctr_init <= cmd.cmd_init;
                        leg      <= 1'b0;
                        steps    <= '0;
                        state    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (abort) begin
                        res_aborted <= 1'b1;
                        res_steps   <= steps;
                        state       <= ST_DONE;
                    end else begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    steps <= steps + 1'b1;
                    if (abort) begin
                        res_aborted <= 1'b1;
                        res_steps   <= steps + 1'b1;
                        state       <= ST_DONE;
                    end else if (final_hit) begin
                        res_aborted <= 1'b0;
                        res_steps   <= steps + 1'b1;
                        state       <= ST_DONE;
                    end else if (turn) begin
                        leg <= 1'b1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_udc_sequencer.sv
// Directed bench for udc_sequencer driving a behavioural up/down counter.
module tb_udc_sequencer;
    import udc_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       abort;
    logic       ctr_rst;
    logic       ctr_mode;
    logic [7:0] ctr_init;
    logic [7:0] ctr_count;
    logic       busy;
    logic       done;
    logic [9:0] res_steps;
    logic       res_aborted;

    int checks   = 0;
    int failures = 0;
    int ncyc;
    int pulses;

    logic [7:0] cnt_a  [0:599];
    logic       rst_a  [0:599];
    logic       mode_a [0:599];

    udc_sequencer_if #(.WIDTH(8)) cif ();

    udc_sequencer #(.WIDTH(8), .SW(10)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd         (cif.slave),
        .abort       (abort),
        .ctr_rst     (ctr_rst),
        .ctr_mode    (ctr_mode),
        .ctr_init    (ctr_init),
        .ctr_count   (ctr_count),
        .busy        (busy),
        .done        (done),
        .res_steps   (res_steps),
        .res_aborted (res_aborted)
    );

    // Neighbouring updown_counter: loads init while its rst is low.
    always_ff @(posedge clk) begin
        if (!ctr_rst) ctr_count <= ctr_init;
        else if (ctr_mode) ctr_count <= ctr_count + 8'd1;
        else ctr_count <= ctr_count - 8'd1;
    end

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one job from IDLE and record every RUN cycle until DONE or exit.
    task automatic run_job(input logic [7:0] i, input logic [7:0] l, input logic d,
                           input logic b, input int abort_at, input int rst_at);
        cif.cmd_init   = i;
        cif.cmd_limit  = l;
        cif.cmd_dir    = d;
        cif.cmd_bounce = b;
        cif.cmd_valid  = 1'b1;
        tick();
        cif.cmd_valid = 1'b0;
        tick();
        ncyc = 0;
        while (busy === 1'b1 && done !== 1'b1 && ncyc < 600) begin
            abort = (ncyc + 1 == abort_at);
            rst   = !(ncyc + 1 == rst_at);
            #1;
            cnt_a[ncyc]  = ctr_count;
            rst_a[ncyc]  = ctr_rst;
            mode_a[ncyc] = ctr_mode;
            ncyc++;
            tick();
            abort = 1'b0;
            rst   = 1'b1;
        end
        check("cycle_bound", 32'(ncyc < 600), 32'd1);
    endtask

    initial begin
        rst = 1'b0;
        abort = 1'b0;
        cif.cmd_valid = 1'b0;
        cif.cmd_init = 8'h00;
        cif.cmd_limit = 8'h00;
        cif.cmd_dir = 1'b0;
        cif.cmd_bounce = 1'b0;
        repeat (3) tick();
        check("rst_ready", cif.cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ctr_rst", ctr_rst, 0);
        check("rst_ctr_mode", ctr_mode, 1);
        check("rst_ctr_init", ctr_init, 0);
        check("rst_steps", res_steps, 0);
        check("rst_aborted", res_aborted, 0);
        rst = 1'b1;
        tick();

        abort = 1'b1;
        tick();
        check("idle_abort_busy", busy, 0);
        check("idle_abort_done", done, 0);
        abort = 1'b0;

        // Up, no bounce.
        run_job(8'h81, 8'h85, 1'b1, 1'b0, 0, 0);
        check("t1_cycles", ncyc, 5);
        check("t1_first", cnt_a[0], 8'h81);
        check("t1_hit", cnt_a[4], 8'h85);
        check("t1_rst_before", rst_a[3], 1);
        check("t1_rst_hit", rst_a[4], 0);
        check("t1_done", done, 1);
        check("t1_ready_done", cif.cmd_ready, 0);
        check("t1_steps", res_steps, 5);
        check("t1_aborted", res_aborted, 0);
        check("t1_reload", ctr_count, 8'h81);
        tick();
        check("t1_idle_done", done, 0);
        check("t1_idle_ready", cif.cmd_ready, 1);
        check("t1_hold_steps", res_steps, 5);

        // Up with bounce.
        run_job(8'h10, 8'h13, 1'b1, 1'b1, 0, 0);
        check("t2_cycles", ncyc, 7);
        check("t2_turn", cnt_a[3], 8'h13);
        check("t2_back", cnt_a[4], 8'h12);
        check("t2_end", cnt_a[6], 8'h10);
        check("t2_mode_up", mode_a[2], 1);
        check("t2_mode_fall", mode_a[3], 0);
        check("t2_rst_turn", rst_a[3], 1);
        check("t2_rst_end", rst_a[6], 0);
        check("t2_steps", res_steps, 7);
        check("t2_reload", ctr_count, 8'h10);
        tick();

        // Down with wrap, then a full 256-cycle leg.
        run_job(8'h02, 8'hFE, 1'b0, 1'b0, 0, 0);
        check("t3_zero", cnt_a[2], 8'h00);
        check("t3_wrap", cnt_a[3], 8'hFF);
        check("t3_steps", res_steps, 5);
        tick();
        run_job(8'h05, 8'h04, 1'b1, 1'b0, 0, 0);
        check("t3b_cycles", ncyc, 256);
        check("t3b_ff", cnt_a[250], 8'hFF);
        check("t3b_end", cnt_a[255], 8'h04);
        check("t3b_steps", res_steps, 256);
        tick();

        // Abort in RUN cycle 3.
        run_job(8'h00, 8'h80, 1'b1, 1'b0, 3, 0);
        check("t5_cycles", ncyc, 3);
        check("t5_rst_pre", rst_a[1], 1);
        check("t5_rst_abort", rst_a[2], 0);
        check("t5_done", done, 1);
        check("t5_aborted", res_aborted, 1);
        check("t5_steps", res_steps, 3);
        check("t5_reload", ctr_count, 8'h00);
        tick();
        check("t5_idle", busy, 0);

        // init == limit with bounce, request held across the job.
        cif.cmd_init = 8'h40;
        cif.cmd_limit = 8'h40;
        cif.cmd_dir = 1'b1;
        cif.cmd_bounce = 1'b1;
        cif.cmd_valid = 1'b1;
        tick();
        check("t4_load_ready", cif.cmd_ready, 0);
        tick();
        check("t4_run_count", ctr_count, 8'h40);
        check("t4_run_rst", ctr_rst, 0);
        tick();
        check("t4_done", done, 1);
        check("t4_steps", res_steps, 1);
        check("t4_aborted", res_aborted, 0);
        check("t4_done_ready", cif.cmd_ready, 0);
        tick();
        check("t4_idle_busy", busy, 0);
        check("t4_idle_ready", cif.cmd_ready, 1);
        tick();
        check("t4_second_load", busy, 1);
        cif.cmd_valid = 1'b0;
        tick();
        tick();
        check("t4_second_done", done, 1);
        check("t4_second_steps", res_steps, 1);
        tick();

        // Reset in RUN cycle 4.
        run_job(8'h00, 8'h80, 1'b1, 1'b0, 0, 4);
        check("t6_cycles", ncyc, 4);
        check("t6_busy", busy, 0);
        check("t6_ready", cif.cmd_ready, 1);
        check("t6_ctr_rst", ctr_rst, 0);
        check("t6_done", done, 0);
        check("t6_steps", res_steps, 0);
        check("t6_aborted", res_aborted, 0);
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            pulses += int'(done);
            tick();
        end
        check("t6_no_done", pulses, 0);

        run_job(8'h20, 8'h21, 1'b1, 1'b0, 0, 0);
        check("t7_steps", res_steps, 2);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
